// File: rtl/gate_tt_sequencer.sv
// Truth-table sweep controller for a 2-input gate: drives AB=00..11, samples Y after a settle time.
// Optional GATE_TT_SEQ_STOP_ON_FAIL_EN: end the sweep on the first mismatching vector.
module gate_tt_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] expect_tt,
  output logic       gate_a,
  output logic       gate_b,
  input  logic       gate_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] fail_idx
);

  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {StIdle, StDrive, StSettle, StSample, StDone} state_e;

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  tt_q, tt_d;
  logic [3:0]  mask_d;
  logic [1:0]  fidx_d;
  logic        pass_d;
  logic        gate_a_d, gate_b_d;
  logic        mismatch;

  assign mismatch = (gate_y != tt_q[idx_q]);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tt_d     = tt_q;
    mask_d   = fail_mask;
    fidx_d   = fail_idx;
    pass_d   = pass;
    gate_a_d = gate_a;
    gate_b_d = gate_b;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          tt_d    = expect_tt;
          mask_d  = 4'b0000;
          fidx_d  = 2'd0;
          pass_d  = 1'b0;
          idx_d   = 2'd0;
          state_d = StDrive;
        end
      end
      StDrive: begin
        cnt_d   = SettleLoad;
        state_d = (SETTLE_CYCLES == 0) ? StSample : StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StSample;
      end
      StSample: begin
        if (mismatch) begin
          mask_d[idx_q] = 1'b1;
          if (fail_mask == 4'b0000) fidx_d = idx_q;
        end
`ifdef GATE_TT_SEQ_STOP_ON_FAIL_EN
        if (mismatch || idx_q == 2'd3) begin
`else
        if (idx_q == 2'd3) begin
`endif
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = StDrive;
        end
      end
      StDone: begin
        pass_d  = (fail_mask == 4'b0000);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Vector is launched together with entry into DRIVE so it is stable for the whole window.
    if (state_d == StDrive) begin
      gate_a_d = idx_d[1];
      gate_b_d = idx_d[0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      idx_q     <= 2'd0;
      cnt_q     <= 4'd0;
      tt_q      <= 4'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= 4'd0;
      fail_idx  <= 2'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tt_q      <= tt_d;
      gate_a    <= gate_a_d;
      gate_b    <= gate_b_d;
      // busy falls and done rises on the edge that leaves DONE
      busy      <= (state_d != StIdle);
      done      <= (state_q == StDone);
      pass      <= pass_d;
      fail_mask <= mask_d;
      fail_idx  <= fidx_d;
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Directed bench for gate_tt_sequencer: NOR/stuck/OR gate models, restart, reset and zero-settle cases.
module tb_gate_tt_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] expect_tt;
  logic       gate_a, gate_b, gate_y, busy, done, pass;
  logic [3:0] fail_mask;
  logic [1:0] fail_idx;
  logic       gate_a0, gate_b0, gate_y0, busy0, done0, pass0;
  logic [3:0] fail_mask0;
  logic [1:0] fail_idx0;
  int         mode;  // 0 NOR, 1 stuck-at-0, 2 OR
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  always_comb begin
    gate_y = 1'b0;
    case (mode)
      0:       gate_y = ~(gate_a | gate_b);
      1:       gate_y = 1'b0;
      default: gate_y = gate_a | gate_b;
    endcase
  end
  assign gate_y0 = ~(gate_a0 | gate_b0);

  gate_tt_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
    .gate_a(gate_a), .gate_b(gate_b), .gate_y(gate_y), .busy(busy), .done(done),
    .pass(pass), .fail_mask(fail_mask), .fail_idx(fail_idx)
  );

  gate_tt_sequencer #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .expect_tt(expect_tt),
    .gate_a(gate_a0), .gate_b(gate_b0), .gate_y(gate_y0), .busy(busy0), .done(done0),
    .pass(pass0), .fail_mask(fail_mask0), .fail_idx(fail_idx0)
  );

  // Pulse start (edge 0) and return k of the negedge after edge k where done is seen, else -1.
  task automatic run_sweep(input bit which, input bit imm, output int done_at);
    done_at = -1;
    if (!imm) @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if ((which ? done0 : done) === 1'b1) begin
        done_at = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; expect_tt = 4'b0001; mode = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({gate_a, gate_b, busy, done, pass, fail_mask, fail_idx} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_dut got %b want 0", {gate_a, gate_b, busy, done, pass, fail_mask, fail_idx});
    end
    n_vec++;
    if ({gate_a0, gate_b0, busy0, done0, pass0, fail_mask0, fail_idx0} !== 11'd0) begin
      n_err++;
      $display("FAIL reset_dut0 got %b want 0",
               {gate_a0, gate_b0, busy0, done0, pass0, fail_mask0, fail_idx0});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_nor();
    logic [1:0] v;
    mode = 0; expect_tt = 4'b0001;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 2) expect_tt = 4'b1110;  // must not disturb the latched table
      v = 2'(k / 4);
      n_vec++;
      if ({gate_a, gate_b, busy, done} !== {v, 2'b10}) begin
        n_err++;
        $display("FAIL nor_vec k=%0d got ab/busy/done=%b want %b", k, {gate_a, gate_b, busy, done},
                 {v, 2'b10});
      end
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL nor_done_early got %b want 0", done);
    end
    @(negedge clk);
    n_vec++;
    if ({done, busy, pass, fail_mask, fail_idx} !== {3'b101, 4'b0000, 2'd0}) begin
      n_err++;
      $display("FAIL nor_result got %b want 101_0000_00", {done, busy, pass, fail_mask, fail_idx});
    end
    @(negedge clk);
    n_vec++;
    if ({done, pass} !== 2'b01) begin
      n_err++; $display("FAIL nor_done_pulse got done/pass=%b want 01", {done, pass});
    end
    expect_tt = 4'b0001;
  endtask

  task automatic test_stuck();
    int d;
    mode = 1; expect_tt = 4'b0001;
    run_sweep(1'b0, 1'b0, d);
    n_vec++;
`ifdef GATE_TT_SEQ_STOP_ON_FAIL_EN
    if (d !== 5) begin
      n_err++; $display("FAIL stuck_done_cycle got %0d want 5", d);
    end
`else
    if (d !== 17) begin
      n_err++; $display("FAIL stuck_done_cycle got %0d want 17", d);
    end
`endif
    n_vec++;
    if ({pass, fail_mask, fail_idx} !== {1'b0, 4'b0001, 2'd0}) begin
      n_err++;
      $display("FAIL stuck_result got %b want 0_0001_00", {pass, fail_mask, fail_idx});
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if ({busy, pass, fail_mask, fail_idx} !== {2'b00, 4'b0001, 2'd0}) begin
      n_err++;
      $display("FAIL stuck_hold got %b want 00_0001_00", {busy, pass, fail_mask, fail_idx});
    end
    n_vec++;
`ifdef GATE_TT_SEQ_STOP_ON_FAIL_EN
    if ({gate_a, gate_b} !== 2'b00) begin
      n_err++; $display("FAIL stuck_last_vec got %b want 00", {gate_a, gate_b});
    end
`else
    if ({gate_a, gate_b} !== 2'b11) begin
      n_err++; $display("FAIL stuck_last_vec got %b want 11", {gate_a, gate_b});
    end
`endif
  endtask

  task automatic test_or();
    int d;
    mode = 2; expect_tt = 4'b0001;
    run_sweep(1'b0, 1'b0, d);
    n_vec++;
`ifdef GATE_TT_SEQ_STOP_ON_FAIL_EN
    if ({d == 5, fail_mask, fail_idx, pass} !== {1'b1, 4'b0001, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL or_result got d=%0d mask=%b idx=%0d pass=%b want d=5 mask=0001 idx=0 pass=0",
               d, fail_mask, fail_idx, pass);
    end
`else
    if ({d == 17, fail_mask, fail_idx, pass} !== {1'b1, 4'b1111, 2'd0, 1'b0}) begin
      n_err++;
      $display("FAIL or_result got d=%0d mask=%b idx=%0d pass=%b want d=17 mask=1111 idx=0 pass=0",
               d, fail_mask, fail_idx, pass);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int d;
    mode = 0;
    // start raised in the cycle right after the previous done
    run_sweep(1'b0, 1'b1, d);
    n_vec++;
    if (d !== 17) begin
      n_err++; $display("FAIL b2b_first_done got %0d want 17", d);
    end
    run_sweep(1'b0, 1'b1, d);
    n_vec++;
    if ({d == 17, pass, fail_mask} !== {2'b11, 4'b0000}) begin
      n_err++;
      $display("FAIL b2b_second got d=%0d pass=%b mask=%b want d=17 pass=1 mask=0000", d, pass,
               fail_mask);
    end
  endtask

  task automatic test_restart_ignored();
    int d = -1;
    int extra = 0;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      if (done === 1'b1 && d < 0) d = k;
      else if (done === 1'b1) extra++;
    end
    n_vec++;
    if (d !== 17) begin
      n_err++; $display("FAIL restart_done_cycle got %0d want 17", d);
    end
    n_vec++;
    if (extra !== 0) begin
      n_err++; $display("FAIL restart_extra_done got %0d want 0", extra);
    end
    n_vec++;
    if ({pass, fail_mask} !== 5'b1_0000) begin
      n_err++; $display("FAIL restart_result got %b want 1_0000", {pass, fail_mask});
    end
  endtask

  task automatic test_reset_mid();
    int d;
    int seen = 0;
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
`ifndef GATE_TT_SEQ_STOP_ON_FAIL_EN
    n_vec++;
    if ({busy, gate_a, gate_b, fail_mask} !== 7'b1_10_0011) begin
      n_err++;
      $display("FAIL mid_pre_reset got %b want 1100011", {busy, gate_a, gate_b, fail_mask});
    end
`endif
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy, gate_a, gate_b, fail_mask, done} !== 8'd0) begin
      n_err++;
      $display("FAIL mid_async_reset got %b want 0", {busy, gate_a, gate_b, fail_mask, done});
    end
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) seen++;
    end
    rst_n = 1'b1;
    n_vec++;
    if (seen !== 0) begin
      n_err++; $display("FAIL mid_no_done got %0d want 0", seen);
    end
    mode = 0;
    run_sweep(1'b0, 1'b0, d);
    n_vec++;
    if ({d == 17, pass} !== 2'b11) begin
      n_err++; $display("FAIL mid_after_release got d=%0d pass=%b want d=17 pass=1", d, pass);
    end
  endtask

  task automatic test_settle0();
    logic [1:0] v;
    int d = -1;
    mode = 0; expect_tt = 4'b0001;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k < 8) begin
        v = 2'(k / 2);
        n_vec++;
        if ({gate_a0, gate_b0} !== v) begin
          n_err++; $display("FAIL s0_vec k=%0d got %b want %b", k, {gate_a0, gate_b0}, v);
        end
      end
      if (done0 === 1'b1 && d < 0) begin
        d = k;
        n_vec++;
        if ({pass0, fail_mask0, busy0} !== 6'b1_0000_0) begin
          n_err++;
          $display("FAIL s0_result got %b want 1_0000_0", {pass0, fail_mask0, busy0});
        end
      end
    end
    n_vec++;
    if (d !== 9) begin
      n_err++; $display("FAIL s0_done_cycle got %0d want 9", d);
    end
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nor();
    test_stuck();
    test_or();
    test_back_to_back();
    test_restart_ignored();
    test_reset_mid();
    test_settle0();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
